// File: rtl/prio_req_arbiter_pkg.sv
// Shared constants and helpers for the request arbiter.
// Selection modes and index-width derivation.
package prio_req_arbiter_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/prio_req_arbiter_pick.sv
// Rotating find-first picker: searches cand starting at start,
// wrapping N-1 -> 0, and reports the absolute winning index.
module prio_pick
  import prio_req_arbiter_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [N-1:0] rot;

  always_comb begin
    int w;
    rot = N'({cand, cand} >> start);
    found = 1'b0;
    winner = '0;
    w = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        w = i + int'(start);
        if (w >= N) w = w - N;
        winner = IDX_W'(w);
      end
    end
  end

endmodule

// File: rtl/prio_req_arbiter.sv
// Registered request arbiter: pending latch, mask, fixed or
// round-robin pick, and a valid/ack grant register.
module prio_req_arbiter
  import prio_req_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = MODE_FIXED,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             flush,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  input  logic             grant_ack,
  output logic [N-1:0]     pending,
  output logic             any_pending
);

  logic [N-1:0]     pend_q;
  logic [N-1:0]     clr;
  logic [N-1:0]     cand;
  logic [N-1:0]     pend_next;
  logic             gv_q;
  logic             anyp_q;
  logic [IDX_W-1:0] gidx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] nxt;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             accept;

  assign accept = gv_q & grant_ack;
  assign clr = accept ? (N'(1) << gidx_q) : '0;
  assign nxt = (gidx_q == IDX_W'(N - 1)) ? '0
             : gidx_q + IDX_W'(1);

  // On ack the search already begins past the line being retired
  assign start = (MODE == MODE_RR) ? (accept ? nxt : ptr_q) : '0;

  assign cand = pend_q & ~mask & ~clr;
  assign pend_next = flush ? '0 : ((pend_q & ~clr) | req);

  prio_pick #(
    .N(N)
  ) u_pick (
    .cand   (cand),
    .start  (start),
    .winner (win),
    .found  (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      gv_q   <= 1'b0;
      gidx_q <= '0;
      ptr_q  <= '0;
      anyp_q <= 1'b0;
    end else begin
      pend_q <= pend_next;
      anyp_q <= |(pend_next & ~mask);
      if (flush) begin
        gv_q <= 1'b0;
      end else if (!gv_q || accept) begin
        gv_q <= found;
        if (found) gidx_q <= win;
      end
      if (MODE == MODE_RR && accept && !flush) ptr_q <= nxt;
    end
  end

  assign grant_valid = gv_q;
  assign grant_idx   = gidx_q;
  assign pending     = pend_q;
  assign any_pending = anyp_q;

endmodule

// File: tb/tb_prio_req_arbiter.sv
// Scoreboard bench for prio_req_arbiter: fixed N=8, round-robin
// N=8 and single-line instances driven with directed vectors.
module tb_prio_req_arbiter;

  logic clk;
  logic rst_n;

  logic [7:0] f_req, f_mask, f_pend;
  logic       f_flush, f_ack, f_gv, f_anyp;
  logic [2:0] f_idx;

  logic [7:0] r_req, r_mask, r_pend;
  logic       r_flush, r_ack, r_gv, r_anyp;
  logic [2:0] r_idx;

  logic [0:0] s_req, s_mask, s_pend, s_idx;
  logic       s_flush, s_ack, s_gv, s_anyp;

  int checks;
  int failures;
  int sbq[$];

  prio_req_arbiter #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(f_req), .mask(f_mask),
    .flush(f_flush), .grant_valid(f_gv), .grant_idx(f_idx),
    .grant_ack(f_ack), .pending(f_pend), .any_pending(f_anyp)
  );

  prio_req_arbiter #(.N(8), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(r_req), .mask(r_mask),
    .flush(r_flush), .grant_valid(r_gv), .grant_idx(r_idx),
    .grant_ack(r_ack), .pending(r_pend), .any_pending(r_anyp)
  );

  prio_req_arbiter #(.N(1), .MODE(1)) u_one (
    .clk(clk), .rst_n(rst_n), .req(s_req), .mask(s_mask),
    .flush(s_flush), .grant_valid(s_gv), .grant_idx(s_idx),
    .grant_ack(s_ack), .pending(s_pend), .any_pending(s_anyp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int d, input int idx);
    int e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_grant: got dut%0d idx %0d expected none",
               d, idx);
    end else begin
      e = sbq.pop_front();
      if (e != d * 16 + idx) begin
        failures++;
        $display("FAIL grant_order: got dut%0d idx %0d expected dut%0d idx %0d",
                 d, idx, e / 16, e % 16);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (f_gv && f_ack && !f_flush) expect_grant(0, int'(f_idx));
      if (r_gv && r_ack && !r_flush) expect_grant(1, int'(r_idx));
      if (s_gv && s_ack && !s_flush) expect_grant(2, int'(s_idx));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d grants outstanding expected 0",
               name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    f_req = '0; f_mask = '0; f_flush = 1'b0; f_ack = 1'b0;
    r_req = '0; r_mask = '0; r_flush = 1'b0; r_ack = 1'b0;
    s_req = '0; s_mask = '0; s_flush = 1'b0; s_ack = 1'b0;

    #2;
    chk("rst_pend", int'(f_pend), 0);
    chk("rst_gv", int'(f_gv), 0);
    chk("rst_idx", int'(f_idx), 0);
    chk("rst_anyp", int'(f_anyp), 0);
    chk("rst_rr_gv", int'(r_gv), 0);
    chk("rst_one_gv", int'(s_gv), 0);
    #10 rst_n = 1'b1;
    step(1);

    // fixed priority walk through A4
    f_req = 8'hA4; step(1); f_req = '0;
    chk("fix_pend", int'(f_pend), 8'hA4);
    chk("fix_latency", int'(f_gv), 0);
    step(1);
    chk("fix_first_gv", int'(f_gv), 1);
    chk("fix_first_idx", int'(f_idx), 2);
    chk("fix_anyp", int'(f_anyp), 1);
    sbq.push_back(2); sbq.push_back(5); sbq.push_back(7);
    f_ack = 1'b1; drain("fix_drain", 10); f_ack = 1'b0;
    chk("fix_end_gv", int'(f_gv), 0);
    chk("fix_end_pend", int'(f_pend), 0);

    // held grant ignores a later mask
    f_req = 8'h06; step(1); f_req = '0; step(1);
    chk("hold_idx0", int'(f_idx), 1);
    f_mask = 8'h02; step(2);
    chk("hold_gv", int'(f_gv), 1);
    chk("hold_idx", int'(f_idx), 1);
    sbq.push_back(1); sbq.push_back(2);
    f_ack = 1'b1; drain("hold_drain", 10); f_ack = 1'b0;
    f_mask = '0;
    chk("hold_end_pend", int'(f_pend), 0);

    // masked-only pending line
    f_mask = 8'h08; f_req = 8'h08; step(1); f_req = '0; step(2);
    chk("mask_pend", int'(f_pend), 8'h08);
    chk("mask_anyp", int'(f_anyp), 0);
    chk("mask_gv", int'(f_gv), 0);
    f_mask = '0; step(1);
    chk("unmask_anyp", int'(f_anyp), 1);
    sbq.push_back(3);
    f_ack = 1'b1; drain("unmask_drain", 10); f_ack = 1'b0;

    // ack while idle changes nothing
    f_mask = 8'h02; f_req = 8'h02; step(1); f_req = '0;
    f_ack = 1'b1; step(2);
    chk("idleack_pend", int'(f_pend), 8'h02);
    chk("idleack_gv", int'(f_gv), 0);
    f_mask = '0;
    sbq.push_back(1);
    drain("idleack_drain", 10); f_ack = 1'b0;

    // set wins over clear, back-to-back grant
    f_req = 8'h30; step(1); f_req = '0; step(1);
    chk("b2b_idx0", int'(f_idx), 4);
    sbq.push_back(4); sbq.push_back(5); sbq.push_back(4);
    f_ack = 1'b1; f_req = 8'h10; step(1); f_req = '0;
    chk("setwins_pend", int'(f_pend), 8'h30);
    chk("b2b_gv", int'(f_gv), 1);
    chk("b2b_idx", int'(f_idx), 5);
    drain("b2b_drain", 10); f_ack = 1'b0;
    chk("b2b_end_pend", int'(f_pend), 0);

    // flush beats ack and req
    f_req = 8'hF0; step(1); f_req = '0; step(1);
    chk("flush_pre_idx", int'(f_idx), 4);
    f_flush = 1'b1; f_ack = 1'b1; f_req = 8'h01; step(1);
    f_flush = 1'b0; f_ack = 1'b0; f_req = '0;
    chk("flush_pend", int'(f_pend), 0);
    chk("flush_gv", int'(f_gv), 0);
    chk("flush_idx", int'(f_idx), 4);
    chk("flush_anyp", int'(f_anyp), 0);
    step(2);
    chk("flush_after_gv", int'(f_gv), 0);

    // asynchronous reset mid-grant
    f_req = 8'h04; step(1); f_req = '0; step(1);
    chk("areset_pre_gv", int'(f_gv), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_gv", int'(f_gv), 0);
    chk("areset_pend", int'(f_pend), 0);
    chk("areset_idx", int'(f_idx), 0);
    #2 rst_n = 1'b1;
    step(2);
    chk("areset_after_gv", int'(f_gv), 0);

    // round-robin sweep
    r_req = 8'hFF; step(1); r_req = '0;
    for (int i = 0; i < 8; i++) sbq.push_back(16 + i);
    r_ack = 1'b1; drain("rr_sweep", 20); r_ack = 1'b0;
    chk("rr_sweep_gv", int'(r_gv), 0);
    chk("rr_sweep_pend", int'(r_pend), 0);

    r_req = 8'h09; step(1); r_req = '0; step(1);
    chk("rr_09_first", int'(r_idx), 0);
    sbq.push_back(16);
    r_ack = 1'b1; step(1); r_ack = 1'b0;
    chk("rr_09_second", int'(r_idx), 3);
    r_req = 8'h01; step(1); r_req = '0;
    chk("rr_rereq_pend", int'(r_pend), 8'h09);
    chk("rr_rereq_hold", int'(r_idx), 3);
    sbq.push_back(16 + 3); sbq.push_back(16);
    r_ack = 1'b1; drain("rr_wrap", 10); r_ack = 1'b0;

    // pointer now 1: line 1 must beat line 0
    r_req = 8'h03; step(1); r_req = '0;
    sbq.push_back(16 + 1); sbq.push_back(16);
    r_ack = 1'b1; drain("rr_ptr", 10); r_ack = 1'b0;
    chk("rr_end_pend", int'(r_pend), 0);

    // single-line build
    s_req = 1'b1; step(1); s_req = 1'b0;
    chk("one_pend", int'(s_pend), 1);
    chk("one_latency", int'(s_gv), 0);
    step(1);
    chk("one_gv", int'(s_gv), 1);
    chk("one_idx", int'(s_idx), 0);
    sbq.push_back(32);
    s_ack = 1'b1; drain("one_drain", 10); s_ack = 1'b0;
    chk("one_end_gv", int'(s_gv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
